// File: rtl/vending_machine_param.sv
// Parametrised vending-machine controller: bounded coin credit, per-product prices,
// serial one-rupee change pulses after a sale or a cancel.
module vending_machine_param #(
   parameter int unsigned COIN_W     = 3,
   parameter int unsigned CREDIT_W   = 5,
   parameter int unsigned MAX_CREDIT = 15,
   parameter int unsigned NUM_PROD   = 4,
   parameter int unsigned PRICE_W    = 4,
   parameter logic [NUM_PROD*PRICE_W-1:0] PRICE_TABLE = {4'd7, 4'd5, 4'd4, 4'd3},
   localparam int unsigned SEL_W     = $clog2(NUM_PROD)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_valid,
   input  logic [COIN_W-1:0]   coin_val,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel,
   input  logic                cancel,
   output logic                coin_rej,
   output logic                sel_rej,
   output logic                prod_valid,
   output logic [SEL_W-1:0]    prod_id,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam int unsigned CMP_W = (CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W;

   typedef enum logic [1:0] {StIdle, StVend, StChange} state_e;

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [SEL_W-1:0]    prod_id_q, prod_id_d;
   logic                coin_rej_q, coin_rej_d;
   logic                sel_rej_q, sel_rej_d;
   logic                prod_valid_q, prod_valid_d;
   logic                change_valid_q, change_valid_d;
   logic                busy_q, busy_d;

   logic [PRICE_W-1:0]  price;
   logic                sel_in_range;
   logic                afford;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_fits;
   logic                coin_nz;

   // Explicit range check so a non-power-of-two NUM_PROD never indexes past the table.
   always_comb begin
      price        = '0;
      sel_in_range = 1'b0;
      for (int unsigned i = 0; i < NUM_PROD; i++) begin
         if (32'(sel) == i) begin
            price        = PRICE_TABLE[i*PRICE_W +: PRICE_W];
            sel_in_range = 1'b1;
         end
      end
   end

   assign afford    = CMP_W'(credit_q) >= CMP_W'(price);
   assign coin_sum  = (CREDIT_W+1)'(credit_q) + (CREDIT_W+1)'(coin_val);
   assign coin_fits = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
   assign coin_nz   = coin_val != '0;

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      prod_id_d      = prod_id_q;
      coin_rej_d     = 1'b0;
      sel_rej_d      = 1'b0;
      prod_valid_d   = 1'b0;
      change_valid_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cancel && credit_q != '0) begin
               state_d    = StChange;
               coin_rej_d = coin_valid;
            end else if (sel_valid) begin
               coin_rej_d = coin_valid;
               if (sel_in_range && afford) begin
                  credit_d     = CREDIT_W'(CMP_W'(credit_q) - CMP_W'(price));
                  prod_id_d    = sel;
                  prod_valid_d = 1'b1;
                  state_d      = StVend;
               end else begin
                  sel_rej_d = 1'b1;
               end
            end else if (coin_valid && coin_nz) begin
               if (coin_fits) begin
                  credit_d = CREDIT_W'(coin_sum);
               end else begin
                  coin_rej_d = 1'b1;
               end
            end
         end
         StVend: begin
            state_d    = (credit_q != '0) ? StChange : StIdle;
            coin_rej_d = coin_valid && coin_nz;
            sel_rej_d  = sel_valid;
         end
         StChange: begin
            coin_rej_d = coin_valid && coin_nz;
            sel_rej_d  = sel_valid;
            if (credit_q != '0) begin
               change_valid_d = 1'b1;
               credit_d       = credit_q - CREDIT_W'(1);
               if (credit_q == CREDIT_W'(1)) begin
                  state_d = StIdle;
               end
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = state_d != StIdle;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         credit_q       <= '0;
         prod_id_q      <= '0;
         coin_rej_q     <= 1'b0;
         sel_rej_q      <= 1'b0;
         prod_valid_q   <= 1'b0;
         change_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         prod_id_q      <= prod_id_d;
         coin_rej_q     <= coin_rej_d;
         sel_rej_q      <= sel_rej_d;
         prod_valid_q   <= prod_valid_d;
         change_valid_q <= change_valid_d;
         busy_q         <= busy_d;
      end
   end

   assign coin_rej     = coin_rej_q;
   assign sel_rej      = sel_rej_q;
   assign prod_valid   = prod_valid_q;
   assign prod_id      = prod_id_q;
   assign change_valid = change_valid_q;
   assign credit       = credit_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: expected pulses queued at stimulus time,
// popped by a negedge monitor as the DUT emits them.
module tb_vending_machine_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_valid;
   logic [2:0] coin_val;
   logic       sel_valid;
   logic [1:0] sel;
   logic       cancel;
   logic       coin_rej;
   logic       sel_rej;
   logic       prod_valid;
   logic [1:0] prod_id;
   logic       change_valid;
   logic [4:0] credit;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   // prod: expected prod_id; others: expected credit seen alongside the pulse
   int q_prod[$];
   int q_change[$];
   int q_coin_rej[$];
   int q_sel_rej[$];

   vending_machine_param dut (
      .clk          (clk),
      .rst          (rst),
      .coin_valid   (coin_valid),
      .coin_val     (coin_val),
      .sel_valid    (sel_valid),
      .sel          (sel),
      .cancel       (cancel),
      .coin_rej     (coin_rej),
      .sel_rej      (sel_rej),
      .prod_valid   (prod_valid),
      .prod_id      (prod_id),
      .change_valid (change_valid),
      .credit       (credit),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (prod_valid) begin
            if (q_prod.size() == 0) check("prod_unexpected", 1, 0);
            else check("prod_id", int'(prod_id), q_prod.pop_front());
         end
         if (change_valid) begin
            if (q_change.size() == 0) check("change_unexpected", 1, 0);
            else check("change_credit", int'(credit), q_change.pop_front());
         end
         if (coin_rej) begin
            if (q_coin_rej.size() == 0) check("coin_rej_unexpected", 1, 0);
            else check("coin_rej_credit", int'(credit), q_coin_rej.pop_front());
         end
         if (sel_rej) begin
            if (q_sel_rej.size() == 0) check("sel_rej_unexpected", 1, 0);
            else check("sel_rej_credit", int'(credit), q_sel_rej.pop_front());
         end
      end
   end

   // Drive one cycle of inputs; returns #1 after the edge that sampled them.
   task automatic apply(input logic cv, input int cval, input logic sv, input int s,
                        input logic c);
      coin_valid = cv;
      coin_val   = 3'(cval);
      sel_valid  = sv;
      sel        = 2'(s);
      cancel     = c;
      @(posedge clk);
      #1;
      coin_valid = 1'b0;
      coin_val   = '0;
      sel_valid  = 1'b0;
      sel        = '0;
      cancel     = 1'b0;
   endtask

   task automatic coin(input int v);
      apply(1'b1, v, 1'b0, 0, 1'b0);
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (busy && n < max_cycles) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy) check("idle_timeout", int'(busy), 0);
   endtask

   task automatic settle(input string tag);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_prod_left"}, q_prod.size(), 0);
      check({tag, "_change_left"}, q_change.size(), 0);
      check({tag, "_coin_rej_left"}, q_coin_rej.size(), 0);
      check({tag, "_sel_rej_left"}, q_sel_rej.size(), 0);
   endtask

   initial begin
      rst        = 1'b1;
      coin_valid = 1'b0;
      coin_val   = '0;
      sel_valid  = 1'b0;
      sel        = '0;
      cancel     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_credit", int'(credit), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_prod_valid", int'(prod_valid), 0);
      check("rst_prod_id", int'(prod_id), 0);
      check("rst_change_valid", int'(change_valid), 0);
      check("rst_coin_rej", int'(coin_rej), 0);
      check("rst_sel_rej", int'(sel_rej), 0);
      rst = 1'b0;

      // Exact payment, no change
      coin(1);
      check("t1_credit1", int'(credit), 1);
      coin(2);
      check("t1_credit3", int'(credit), 3);
      q_prod.push_back(0);
      apply(1'b0, 0, 1'b1, 0, 1'b0);
      check("t1_credit0", int'(credit), 0);
      check("t1_busy_vend", int'(busy), 1);
      check("t1_prod_valid", int'(prod_valid), 1);
      @(posedge clk);
      #1;
      check("t1_busy_after", int'(busy), 0);
      check("t1_prod_drop", int'(prod_valid), 0);
      settle("t1");

      // Zero-valued coin is ignored
      apply(1'b1, 0, 1'b0, 0, 1'b0);
      check("t1b_zero_coin", int'(credit), 0);

      // One rupee of change
      coin(2);
      coin(2);
      check("t2_credit4", int'(credit), 4);
      q_prod.push_back(0);
      q_change.push_back(0);
      apply(1'b0, 0, 1'b1, 0, 1'b0);
      check("t2_credit1", int'(credit), 1);
      wait_idle(10);
      check("t2_credit_end", int'(credit), 0);
      settle("t2");

      // Insufficient credit, then cancel refund
      coin(5);
      q_sel_rej.push_back(5);
      apply(1'b0, 0, 1'b1, 3, 1'b0);
      check("t3_credit_kept", int'(credit), 5);
      for (int i = 4; i >= 0; i--) q_change.push_back(i);
      apply(1'b0, 0, 1'b0, 0, 1'b1);
      check("t3_busy", int'(busy), 1);
      wait_idle(10);
      check("t3_credit_end", int'(credit), 0);
      settle("t3");

      // Overflow rejection at MAX_CREDIT, then large change
      coin(5);
      coin(5);
      coin(5);
      check("t4_credit15", int'(credit), 15);
      q_coin_rej.push_back(15);
      coin(2);
      check("t4_credit_kept", int'(credit), 15);
      q_prod.push_back(3);
      for (int i = 7; i >= 0; i--) q_change.push_back(i);
      apply(1'b0, 0, 1'b1, 3, 1'b0);
      check("t4_credit8", int'(credit), 8);
      wait_idle(20);
      settle("t4");

      // Coin together with an accepted selection
      coin(5);
      q_prod.push_back(1);
      q_coin_rej.push_back(1);
      q_change.push_back(0);
      apply(1'b1, 2, 1'b1, 1, 1'b0);
      check("t5a_credit1", int'(credit), 1);
      wait_idle(10);
      settle("t5a");

      // Coin during CHANGE
      coin(4);
      for (int i = 3; i >= 0; i--) q_change.push_back(i);
      apply(1'b0, 0, 1'b0, 0, 1'b1);
      q_coin_rej.push_back(3);
      coin(2);
      wait_idle(10);
      check("t5b_credit_end", int'(credit), 0);
      settle("t5b");

      // Selection during VEND
      coin(5);
      q_prod.push_back(0);
      q_sel_rej.push_back(2);
      q_change.push_back(1);
      q_change.push_back(0);
      apply(1'b0, 0, 1'b1, 0, 1'b0);
      apply(1'b0, 0, 1'b1, 1, 1'b0);
      wait_idle(10);
      settle("t5c");

      // Reset in the middle of a 4-pulse refund
      coin(4);
      check("t6_credit4", int'(credit), 4);
      q_change.push_back(3);
      q_change.push_back(2);
      apply(1'b0, 0, 1'b0, 0, 1'b1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("t6_pulse2", int'(change_valid), 1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_rst_credit", int'(credit), 0);
      check("t6_rst_change", int'(change_valid), 0);
      check("t6_rst_busy", int'(busy), 0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      settle("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised vending-machine control unit, successor to the fixed Rs.3 single-product controller. It accepts coins of arbitrary configured value into a bounded credit register and serves NUM_PROD products, each with its own price. After a sale it pays back any surplus as a serial stream of one-unit change pulses, and a cancel request refunds the full credit. It sits between the coin validator / keypad front end and the dispense / coin-hopper actuators.

Parameters:
COIN_W, 3, width of coin value input in rupees; value 0 = no coin.
CREDIT_W, 5, width of credit register.
MAX_CREDIT, 15, largest credit held; must be <= 2**CREDIT_W-1.
NUM_PROD, 4, number of products; must be >= 2.
PRICE_W, 4, width of one price entry.
PRICE_TABLE, {4'd7,4'd5,4'd4,4'd3}, flattened prices; entry i at bits [i*PRICE_W +: PRICE_W], so prod0=3, prod1=4, prod2=5, prod3=7.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
coin_valid  in  1  coin present this cycle.
coin_val  in  COIN_W  coin value in rupees.
sel_valid  in  1  product selection request.
sel  in  $clog2(NUM_PROD)  product index.
cancel  in  1  refund request.
coin_rej  out  1  one-cycle pulse: coin not credited and must be returned.
sel_rej  out  1  one-cycle pulse: selection refused.
prod_valid  out  1  one-cycle pulse: dispense product prod_id.
prod_id  out  $clog2(NUM_PROD)  product being dispensed; holds its last value otherwise.
change_valid  out  1  one pulse per rupee returned.
credit  out  CREDIT_W  current credit, registered.
busy  out  1  high in VEND or CHANGE.

Behaviour:
- All outputs are registered. An input sampled at edge k produces its response after edge k.
- Reset: state=IDLE. credit, prod_id, coin_rej, sel_rej, prod_valid, change_valid all 0. Reset mid-VEND or mid-CHANGE abandons the operation: no further pulses, and the remaining credit is discarded.
- States:
  - IDLE: accepts coins, selections and cancel.
  - VEND: one cycle.
  - CHANGE: one cycle per rupee of credit.
- IDLE priority per cycle: cancel > sel_valid > coin_valid.
- cancel in IDLE:
  - credit>0: go to CHANGE.
  - credit==0: no-op.
- sel_valid in IDLE (no cancel), with price p = PRICE_TABLE entry for sel:
  - sel >= NUM_PROD, or credit < p: sel_rej=1 for one cycle; credit unchanged.
  - Otherwise: credit <= credit-p, prod_id <= sel, prod_valid=1 for one cycle, state <= VEND.
- coin_valid in IDLE (no accepted cancel/sel):
  - coin_val==0: ignored, no pulse.
  - credit+coin_val <= MAX_CREDIT: credit += coin_val. Compute the sum at CREDIT_W+1 bits so there is no wrap.
  - Otherwise: coin_rej=1; credit unchanged.
- A coin_valid coinciding with a cancel or sel_valid that was acted on (including a sel_rej): coin_rej=1.
- VEND: prod_valid drops. Next state is CHANGE if credit>0, else IDLE.
- CHANGE: each cycle change_valid=1 and credit <= credit-1. The state returns to IDLE on the edge where credit goes 1->0. Exactly N pulses are produced for N rupees, back-to-back.
- While busy:
  - coin_valid with nonzero value: coin_rej pulse.
  - sel_valid: sel_rej pulse.
  - cancel: ignored.
- Timing: with a sel accepted at edge k, prod_valid is high k..k+1 and change pulses occupy k+2..k+1+r, where r is the remaining credit.

Test Plan:
- Reset, then coin 1, coin 2, sel=0 -> credit 1, then 3; prod_valid one cycle with prod_id=0; credit 0; no change_valid; busy falls after VEND.
- Coin 2, coin 2, sel=0 -> prod_valid with prod_id=0, then exactly 1 change_valid pulse; credit 4->1->0; back to IDLE.
- Coin 5, sel=3 -> sel_rej pulse, credit stays 5. Then cancel -> 5 consecutive change_valid pulses, credit 5..0, no prod_valid.
- Overflow: coins 5, 5, 5 (credit 15), then coin 2 -> coin_rej, credit 15. Then sel=3 -> prod_id=3, 8 change pulses.
- Simultaneous and busy cases:
  - coin 2 together with accepted sel -> coin_rej and the vend proceeds.
  - coin during CHANGE -> coin_rej, pulse count unaffected.
  - sel during VEND -> sel_rej.
- rst asserted in the 2nd of 4 change pulses -> next cycle credit 0, change_valid 0, busy 0, no further pulses.
